alu_mul_seq: RTL
================

# alu_mul_seq

Iterative 32×32 → low-32 multiplier that gets its additions from the shared 32-bit integer ALU and does not own an adder. It computes shift-and-add partial products, borrowing the ALU through a req/gnt pair whenever a partial-product add is needed. The pipeline arbiter owns the ALU and grants it when the pipeline does not need it. The block sits beside the execute stage and serves the MUL instruction.

## Interface
Parameters:
- WIDTH, 32, operand/result width; only 32 is supported (matches the ALU).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a multiply; sampled only in IDLE.
- op_a  in  32  multiplicand.
- op_b  in  32  multiplier.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when result is valid.
- result  out  32  low 32 bits of op_a*op_b; held until next done.
- alu_req  out  1  ALU needed this cycle.
- alu_gnt  in  1  ALU granted this cycle (same-cycle response from arbiter).
- alu_a  out  32  to ALU data_a.
- alu_b  out  32  to ALU data_b.
- alu_pattern  out  4  to ALU op select.
- alu_out  in  32  ALU result.

## Operation
- Internal registers:
  - P: 32-bit accumulator.
  - M: multiplicand, shifts left.
  - Q: multiplier, shifts right.
  - state: IDLE or RUN.
- IDLE, start=1:
  - P←0, M←op_a, Q←op_b, busy←1, state←RUN.
  - start=0: no change.
- RUN, Q==0: result←P, done←1, busy←0, state←IDLE.
- RUN, Q≠0, Q[0]==0: M←M<<1, Q←Q>>1. No ALU use.
- RUN, Q≠0, Q[0]==1: alu_req=1.
  - alu_gnt=1: P←alu_out, M←M<<1, Q←Q>>1.
  - alu_gnt=0: hold all registers (stall).
- ALU drive:
  - alu_req=1: alu_a=P, alu_b=M, alu_pattern=4'd1 (add).
  - Otherwise: alu_a=0, alu_b=0, alu_pattern=4'd0.
  - alu_req and the ALU drive are combinational from state/Q; they must not depend on alu_gnt.
- Arithmetic:
  - All values are 32-bit with wrap-around: ALU add overflow is discarded and bits shifted out of M are lost.
  - The low 32 bits of the product are identical for signed and unsigned operands, so no sign handling is needed.
- start while busy is ignored. The operand inputs are not re-sampled during RUN.
- Early exit: RUN ends as soon as Q==0, so bit positions above the highest set bit of op_b cost nothing.

## Timing
- Reset values (rst high at a clock edge):
  - state=IDLE; busy=0, done=0, result=0.
  - P=0, M=0, Q=0.
  - alu_req=0, alu_a=0, alu_b=0, alu_pattern=0.
- Reset mid-RUN aborts the operation:
  - No done pulse.
  - The ALU request drops in the cycle after the reset edge.
- Let h be the number of significant bits of op_b (h=0 for op_b=0, 32 for bit31 set) and s the number of stall cycles.
  - RUN lasts h+1+s cycles.
  - done rises h+2+s cycles after the edge that sampled start.
  - Example: op_b=0 → done 2 cycles after start.
- busy rises the cycle after the start sample. It falls in the same cycle that done rises.
- done is high for exactly one cycle. result updates at that same edge and holds until the next done.
- A new start may be presented in the cycle done is high. It is accepted at the next edge, giving back-to-back operations with no idle gap.
- Stalls: while alu_gnt=0 with alu_req=1, alu_req, alu_a, alu_b and alu_pattern stay stable until granted.

## Test plan
- op_a=6, op_b=7, alu_gnt tied 1 → done 5 cycles after start, result=42, alu_req high in 3 cycles.
- op_a=0x12345678, op_b=0 → done 2 cycles after start, result=0, alu_req never asserted.
- op_a=op_b=0xFFFFFFFF, gnt=1 → done 34 cycles after start, result=0x00000001. op_a=0xFFFFFFFD (−3), op_b=5 → result=0xFFFFFFF1 (−15).
- op_a=6, op_b=7, alu_gnt=0 for 4 cycles on the first request → done 9 cycles after start, result=42, ALU outputs stable throughout the stall.
- Assert start with new operands while busy → ignored; first result correct. start in the done cycle → second operation begins at the next edge.
- rst pulse 3 cycles into op_a=6, op_b=7 → no done, busy=0 and alu_req=0 next cycle, result=0. A subsequent start runs normally.

Source files
------------

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-and-add 32x32 multiplier that borrows the shared ALU for its adds
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_pattern,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [3:0] ALU_ADD = 4'd1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] p, p_next;
  logic [WIDTH-1:0] m, m_next;
  logic [WIDTH-1:0] q, q_next;
  logic [WIDTH-1:0] result_next;
  logic             done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      p      <= '0;
      m      <= '0;
      q      <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      p      <= p_next;
      m      <= m_next;
      q      <= q_next;
      result <= result_next;
      done   <= done_next;
    end
  end

  assign busy = (state == RUN);

  // The ALU drive depends only on state and Q so the arbiter sees a stable
  // request; alu_gnt only decides whether the registers advance.
  always_comb begin
    state_next  = state;
    p_next      = p;
    m_next      = m;
    q_next      = q;
    result_next = result;
    done_next   = 1'b0;
    alu_req     = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_pattern = 4'd0;
    case (state)
      IDLE: begin
        if (start) begin
          p_next     = '0;
          m_next     = op_a;
          q_next     = op_b;
          state_next = RUN;
        end
      end
      RUN: begin
        if (q == '0) begin
          result_next = p;
          done_next   = 1'b1;
          state_next  = IDLE;
        end else if (!q[0]) begin
          m_next = m << 1;
          q_next = q >> 1;
        end else begin
          alu_req     = 1'b1;
          alu_a       = p;
          alu_b       = m;
          alu_pattern = ALU_ADD;
          if (alu_gnt) begin
            p_next = alu_out;
            m_next = m << 1;
            q_next = q >> 1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
